// File: rtl/irq_controller_vec.sv
// Vectored interrupt controller: per-line edge/level capture, mie/global masking,
// fixed-priority selection (index 0 highest) and a trap/mret handshake with one-hot ack.
module irq_controller_vec #(
  parameter int unsigned          N_IRQ     = 16,
  parameter logic [N_IRQ-1:0]     EDGE_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             global_ie_i,
  input  logic             stall_i,
  input  logic             exception_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             in_service_o
);

  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SERVICE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_IRQ-1:0]  r_req_q;
  logic [N_IRQ-1:0]  r_pend_q;
  logic [N_IRQ-1:0]  r_ret_q;
  logic [ID_W-1:0]   r_cur_id;

  logic [N_IRQ-1:0]  w_pending;
  logic [N_IRQ-1:0]  w_eligible;
  logic [ID_W-1:0]   w_sel_id;
  logic              w_take;
  logic [N_IRQ-1:0]  w_ret_nxt;
  logic [N_IRQ-1:0]  w_set;
  logic [N_IRQ-1:0]  w_clr;
  logic [N_IRQ-1:0]  w_pend_nxt;
  logic [4:0]        w_code;

  // Level lines use the registered request so irq_o never sees irq_req_i combinationally.
  assign w_pending  = (r_pend_q & EDGE_MASK) | (r_req_q & ~EDGE_MASK);
  assign w_eligible = w_pending & mie_i & {N_IRQ{global_ie_i}};

  always_comb begin
    w_sel_id = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (w_eligible[i-1]) w_sel_id = ID_W'(i - 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ret_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        w_take = (|w_eligible) & ~stall_i & ~exception_i;
        if (w_take) w_state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (mret_i && !stall_i) begin
          w_state_nxt         = ST_IDLE;
          w_ret_nxt[r_cur_id] = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new edge on the line being taken re-arms it: set beats clear.
  always_comb begin
    w_set = irq_req_i & ~r_req_q & EDGE_MASK;
    w_clr = '0;
    if (w_take) w_clr[w_sel_id] = 1'b1;
    w_pend_nxt = ((r_pend_q & ~w_clr) | w_set) & EDGE_MASK;
  end

  assign w_code       = 5'd16 + 5'(w_sel_id);
  assign irq_o        = w_take;
  assign irq_cause_o  = w_take ? {1'b1, 26'b0, w_code} : 32'h0;
  assign irq_ret_o    = r_ret_q;
  assign in_service_o = (r_state == ST_SERVICE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_req_q  <= '0;
      r_pend_q <= '0;
      r_ret_q  <= '0;
      r_cur_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req_q  <= irq_req_i;
      r_pend_q <= w_pend_nxt;
      r_ret_q  <= w_ret_nxt;
      if (w_take) r_cur_id <= w_sel_id;
    end
  end

endmodule

// File: tb/tb_irq_controller_vec.sv
// Scenario bench for irq_controller_vec: expected causes/acks are queued when
// stimulus is driven and popped when the controller traps or acknowledges.
module tb_irq_controller_vec;

  logic        clk;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [15:0] mie_i;
  logic        global_ie_i;
  logic        stall_i;
  logic        exception_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        in_service_o;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] q_cause[$];
  logic [15:0] q_ret[$];
  logic [31:0] exp_c;
  logic [15:0] exp_r;
  bit          seen;

  // Line 4 is level-triggered, all others edge-triggered.
  irq_controller_vec #(
    .N_IRQ    (16),
    .EDGE_MASK(16'hFFEF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .global_ie_i (global_ie_i),
    .stall_i     (stall_i),
    .exception_i (exception_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_o   (irq_ret_o),
    .in_service_o(in_service_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_irq(input int unsigned max_cyc, output bit found);
    found = 1'b0;
    for (int unsigned k = 0; k < max_cyc && !found; k++) begin
      if (irq_o === 1'b1) found = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; irq_req_i = '0; mie_i = 16'hFFFF; global_ie_i = 1'b1;
    stall_i = 1'b0; exception_i = 1'b0; mret_i = 1'b0;
    repeat (3) nxt();
    #1;
    total++;
    if ({irq_o, in_service_o, irq_ret_o, irq_cause_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: got irq=%b svc=%b ret=%h cause=%h want all 0",
                      irq_o, in_service_o, irq_ret_o, irq_cause_o);
    end
    nxt(); rst_i = 1'b1;
    nxt(); #1;
    total++;
    if ({irq_o, in_service_o, irq_ret_o, irq_cause_o} !== '0) begin
      bad++; $display("FAIL post_reset_idle: got irq=%b svc=%b ret=%h cause=%h want all 0",
                      irq_o, in_service_o, irq_ret_o, irq_cause_o);
    end
  endtask

  task automatic test_single_edge();
    nxt(); irq_req_i[3] = 1'b1; q_cause.push_back(32'h8000_0013); #1;
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL edge3_early: irq_o=%b want 0", irq_o); end
    nxt(); irq_req_i[3] = 1'b0; #1;
    exp_c = q_cause.pop_front(); total++;
    if ({irq_o, irq_cause_o} !== {1'b1, exp_c}) begin
      bad++; $display("FAIL edge3_take: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
    end
    nxt(); #1;
    total++;
    if ({irq_o, in_service_o} !== 2'b01) begin
      bad++; $display("FAIL edge3_service: irq=%b svc=%b want 0 1", irq_o, in_service_o);
    end
    mret_i = 1'b1; q_ret.push_back(16'h0008);
    nxt(); #1;
    exp_r = q_ret.pop_front(); total++;
    if ({irq_ret_o, in_service_o} !== {exp_r, 1'b0}) begin
      bad++; $display("FAIL edge3_ack: ret=%h svc=%b want %h 0", irq_ret_o, in_service_o, exp_r);
    end
    nxt(); mret_i = 1'b0; #1;
    total++;
    if (irq_ret_o !== 16'h0000) begin
      bad++; $display("FAIL second_mret_ack: ret=%h want 0000", irq_ret_o);
    end
  endtask

  task automatic test_priority();
    nxt(); irq_req_i = 16'h0024;
    q_cause.push_back(32'h8000_0012); q_cause.push_back(32'h8000_0015);
    nxt(); irq_req_i = '0; #1;
    wait_irq(4, seen);
    exp_c = q_cause.pop_front(); total++;
    if (!seen || irq_cause_o !== exp_c) begin
      bad++; $display("FAIL prio_first: seen=%b cause=%h want %h", seen, irq_cause_o, exp_c);
    end
    nxt(); #1; mret_i = 1'b1; q_ret.push_back(16'h0004);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if (irq_ret_o !== exp_r) begin
      bad++; $display("FAIL prio_ack2: ret=%h want %h", irq_ret_o, exp_r);
    end
    wait_irq(4, seen);
    exp_c = q_cause.pop_front(); total++;
    if (!seen || irq_cause_o !== exp_c) begin
      bad++; $display("FAIL prio_second: seen=%b cause=%h want %h", seen, irq_cause_o, exp_c);
    end
    nxt(); #1; mret_i = 1'b1; q_ret.push_back(16'h0020);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if (irq_ret_o !== exp_r) begin
      bad++; $display("FAIL prio_ack5: ret=%h want %h", irq_ret_o, exp_r);
    end
  endtask

  task automatic test_exception();
    nxt(); irq_req_i[0] = 1'b1;
    nxt(); irq_req_i[0] = 1'b0; exception_i = 1'b1; #1;
    total++;
    if ({irq_o, irq_cause_o} !== 33'h0) begin
      bad++; $display("FAIL exc_suppress: irq=%b cause=%h want 0 0", irq_o, irq_cause_o);
    end
    nxt(); exception_i = 1'b0; q_cause.push_back(32'h8000_0010); #1;
    exp_c = q_cause.pop_front(); total++;
    if ({irq_o, irq_cause_o} !== {1'b1, exp_c}) begin
      bad++; $display("FAIL exc_then_take: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
    end
    nxt(); exception_i = 1'b1;
    nxt(); exception_i = 1'b0; #1;
    total++;
    if (in_service_o !== 1'b1) begin
      bad++; $display("FAIL exc_in_service: svc=%b want 1", in_service_o);
    end
    mret_i = 1'b1; q_ret.push_back(16'h0001);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if (irq_ret_o !== exp_r) begin
      bad++; $display("FAIL exc_ack: ret=%h want %h", irq_ret_o, exp_r);
    end
  endtask

  task automatic test_stall();
    nxt(); irq_req_i[1] = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); irq_req_i[1] = 1'b0; #1;
      total++;
      if (irq_o !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: irq_o=%b want 0", i, irq_o);
      end
    end
    nxt(); stall_i = 1'b0; q_cause.push_back(32'h8000_0011); #1;
    exp_c = q_cause.pop_front(); total++;
    if ({irq_o, irq_cause_o} !== {1'b1, exp_c}) begin
      bad++; $display("FAIL stall_release: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
    end
    nxt(); mret_i = 1'b1; stall_i = 1'b1;
    nxt(); #1;
    total++;
    if ({irq_ret_o, in_service_o} !== {16'h0000, 1'b1}) begin
      bad++; $display("FAIL mret_stalled: ret=%h svc=%b want 0000 1", irq_ret_o, in_service_o);
    end
    stall_i = 1'b0; q_ret.push_back(16'h0002);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if ({irq_ret_o, in_service_o} !== {exp_r, 1'b0}) begin
      bad++; $display("FAIL mret_after_stall: ret=%h svc=%b want %h 0", irq_ret_o, in_service_o, exp_r);
    end
  endtask

  task automatic test_level();
    nxt(); irq_req_i[4] = 1'b1; mie_i = 16'hFFEF;
    nxt(); #1;
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL level_masked: irq_o=%b want 0", irq_o); end
    nxt(); mie_i = 16'hFFFF; q_cause.push_back(32'h8000_0014); #1;
    exp_c = q_cause.pop_front(); total++;
    if ({irq_o, irq_cause_o} !== {1'b1, exp_c}) begin
      bad++; $display("FAIL level_unmask: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
    end
    nxt(); irq_req_i[4] = 1'b0; mret_i = 1'b1; q_ret.push_back(16'h0010);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if ({irq_ret_o, irq_o} !== {exp_r, 1'b0}) begin
      bad++; $display("FAIL level_ack: ret=%h irq=%b want %h 0", irq_ret_o, irq_o, exp_r);
    end
    nxt(); irq_req_i[4] = 1'b1; mie_i = 16'hFFEF;
    nxt(); irq_req_i[4] = 1'b0;
    nxt(); mie_i = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      #1; total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL level_dropped%0d: irq_o=%b want 0", i, irq_o); end
      nxt();
    end
  endtask

  task automatic test_global_ie();
    nxt(); irq_req_i[6] = 1'b1; global_ie_i = 1'b0;
    nxt(); irq_req_i[6] = 1'b0;
    nxt(); #1;
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL gie_off: irq_o=%b want 0", irq_o); end
    global_ie_i = 1'b1; q_cause.push_back(32'h8000_0016); #1;
    exp_c = q_cause.pop_front(); total++;
    if ({irq_o, irq_cause_o} !== {1'b1, exp_c}) begin
      bad++; $display("FAIL gie_retained: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
    end
    nxt(); mret_i = 1'b1; q_ret.push_back(16'h0040);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if (irq_ret_o !== exp_r) begin bad++; $display("FAIL gie_ack: ret=%h want %h", irq_ret_o, exp_r); end
  endtask

  task automatic test_reset_mid_service();
    nxt(); irq_req_i[0] = 1'b1;
    nxt(); irq_req_i[0] = 1'b0;
    nxt(); irq_req_i[7] = 1'b1;
    nxt(); irq_req_i[7] = 1'b0; #1;
    total++;
    if (in_service_o !== 1'b1) begin bad++; $display("FAIL rst_setup: svc=%b want 1", in_service_o); end
    rst_i = 1'b0; #1;
    total++;
    if ({irq_o, in_service_o, irq_ret_o, irq_cause_o} !== '0) begin
      bad++; $display("FAIL rst_async: irq=%b svc=%b ret=%h cause=%h want all 0",
                      irq_o, in_service_o, irq_ret_o, irq_cause_o);
    end
    nxt(); rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1; total++;
      if ({irq_o, irq_ret_o} !== 17'h0) begin
        bad++; $display("FAIL rst_lost%0d: irq=%b ret=%h want 0 0000", i, irq_o, irq_ret_o);
      end
    end
    nxt(); irq_req_i[7] = 1'b1; q_cause.push_back(32'h8000_0017);
    nxt(); irq_req_i[7] = 1'b0; #1;
    wait_irq(4, seen);
    exp_c = q_cause.pop_front(); total++;
    if (!seen || irq_cause_o !== exp_c) begin
      bad++; $display("FAIL rst_new_edge: seen=%b cause=%h want %h", seen, irq_cause_o, exp_c);
    end
    nxt(); mret_i = 1'b1; q_ret.push_back(16'h0080);
    nxt(); mret_i = 1'b0; #1;
    exp_r = q_ret.pop_front(); total++;
    if (irq_ret_o !== exp_r) begin bad++; $display("FAIL rst_ack7: ret=%h want %h", irq_ret_o, exp_r); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_exception();
    test_stall();
    test_level();
    test_global_ie();
    test_reset_mid_service();
    total++;
    if (q_cause.size() + q_ret.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: left=%0d want 0", q_cause.size() + q_ret.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
